// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment encoder for the
// multiplexed seven-segment display driver.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low a..g on [6:0], DP (off) on [7].
    localparam logic [7:0] HEX_CODE [0:15] = '{
        8'h81, 8'hCF, 8'h92, 8'h86,
        8'hCC, 8'hA4, 8'hA0, 8'h8F,
        8'h80, 8'h84, 8'h88, 8'hE0,
        8'hB1, 8'hC2, 8'hB0, 8'hB8
    };

    function automatic logic [7:0] hex2seg(
        input logic [3:0] nibble,
        input logic       dp
    );
        logic [7:0] c;
        c = HEX_CODE[nibble];
        return {~dp, c[6:0]};
    endfunction

endpackage

// File: rtl/seg_hex_lut.sv
// Combinational hex nibble plus decimal point to
// active-low seven-segment code.
module seg_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] code
);

    assign code = hex2seg(nibble, dp);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with shadow
// register, refresh prescaler and leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int DIV           = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [7:0]            seg_data,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   val_q;
    logic [DIGITS-1:0]     dp_q;

    logic                  adv;
    logic                  wrap;
    logic [DIGITS-1:0]     nz;
    logic [3:0]            nib;
    logic                  dsel;
    logic                  nzsel;
    logic [DIGITS-1:0]     onehot;
    logic [7:0]            code;
    logic                  blank_sel;
    logic [7:0]            seg_next;
    logic [DIGITS-1:0]     an_next;

    assign adv  = (cnt == CW'(DIV - 1));
    assign wrap = adv && (idx == IW'(DIGITS - 1));

    // nz[i] is set when any nibble from i up to the MSB is non-zero.
    always_comb begin
        nz = '0;
        nz[DIGITS-1] = |val_q[4*(DIGITS-1) +: 4];
        for (int i = DIGITS - 2; i >= 0; i--) begin
            nz[i] = nz[i+1] | (|val_q[4*i +: 4]);
        end
    end

    always_comb begin
        nib    = '0;
        dsel   = 1'b0;
        nzsel  = 1'b0;
        onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = val_q[4*i +: 4];
                dsel      = dp_q[i];
                nzsel     = nz[i];
                onehot[i] = 1'b1;
            end
        end
    end

    seg_hex_lut u_lut (
        .nibble (nib),
        .dp     (dsel),
        .code   (code)
    );

    // Digit 0 always shows, even when the whole value is zero.
    assign blank_sel = blank_lz && (idx != '0) && !nzsel;
    assign seg_next  = blank_sel ? SEG_BLANK : code;
    assign an_next   = AN_ACTIVE_LOW ? ~onehot : onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= adv ? '0 : cnt + 1'b1;
            if (adv) begin
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_data <= SEG_BLANK;
            an       <= {DIGITS{AN_ACTIVE_LOW}};
            frame    <= 1'b0;
        end else begin
            seg_data <= seg_next;
            an       <= an_next;
            frame    <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a 4-digit/DIV=3 instance
// and a 1-digit/DIV=1 active-high-anode instance.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blank_lz;

    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg4;
    logic [3:0]  an4;
    logic        fr4;

    logic        load1;
    logic [3:0]  value1;
    logic [0:0]  dp1;
    logic [7:0]  seg1;
    logic [0:0]  an1;
    logic        fr1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] hexc [16] = '{
        8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
        8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8
    };

    logic [16:0] q4 [$];
    logic [16:0] q1 [$];
    int          m_t    = 0;
    logic [15:0] m_val4 = '0;
    logic [3:0]  m_dp4  = '0;
    logic [3:0]  m_val1 = '0;
    logic        m_dp1  = 1'b0;

    seg_scan_driver #(
        .DIGITS        (4),
        .DIV           (3),
        .AN_ACTIVE_LOW (1'b1)
    ) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp       (dp),
        .blank_lz (blank_lz),
        .seg_data (seg4),
        .an       (an4),
        .frame    (fr4)
    );

    seg_scan_driver #(
        .DIGITS        (1),
        .DIV           (1),
        .AN_ACTIVE_LOW (1'b0)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .value    (value1),
        .dp       (dp1),
        .blank_lz (blank_lz),
        .seg_data (seg1),
        .an       (an1),
        .frame    (fr1)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {frame, an[7:0], seg[7:0]} after the edge that ends
    // cycle t, where t counts edges since reset release.
    function automatic logic [16:0] model(
        input logic [15:0] val,
        input logic [3:0]  dpv,
        input logic        blz,
        input int          t,
        input int          nd,
        input int          dv,
        input bit          anlow
    );
        int         d;
        logic [7:0] s;
        logic [7:0] a;
        logic [3:0] n;
        logic       f;
        d = (t / dv) % nd;
        n = val[4*d +: 4];
        s = {~dpv[d], hexc[n][6:0]};
        if (blz && d > 0 && (val >> (4*d)) == 16'h0) s = 8'hFF;
        a = 8'h01 << d;
        if (anlow) a = ~a;
        f = ((t + 1) % (nd * dv)) == 0;
        return {f, a, s};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q4.delete();
            q1.delete();
            m_t    <= 0;
            m_val4 <= '0;
            m_dp4  <= '0;
            m_val1 <= '0;
            m_dp1  <= 1'b0;
        end else begin
            q4.push_back(model(m_val4, m_dp4, blank_lz, m_t, 4, 3, 1'b1));
            q1.push_back(model({12'h0, m_val1}, {3'b0, m_dp1},
                               blank_lz, m_t, 1, 1, 1'b0));
            if (load) begin
                m_val4 <= value;
                m_dp4  <= dp;
            end
            if (load1) begin
                m_val1 <= value1;
                m_dp1  <= dp1[0];
            end
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("seg4", 32'(seg4), 32'(e[7:0]));
                check("an4", 32'(an4), 32'(e[11:8]));
                check("frame4", 32'(fr4), 32'(e[16]));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("seg1", 32'(seg1), 32'(e[7:0]));
                check("an1", 32'(an1), 32'(e[8]));
                check("frame1", 32'(fr1), 32'(e[16]));
            end
        end
    end

    task automatic wait_an(input logic [3:0] a);
        int n;
        n = 0;
        while (an4 !== a && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an4 !== a) check("wait_an_timeout", 32'(an4), 32'(a));
    endtask

    task automatic load4(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp    = d;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        blank_lz = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        load1    = 1'b0;
        value1   = '0;
        dp1      = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_seg4", 32'(seg4), 32'h0FF);
        check("rst_an4", 32'(an4), 32'hF);
        check("rst_frame4", 32'(fr4), 32'h0);
        check("rst_seg1", 32'(seg1), 32'h0FF);
        check("rst_an1", 32'(an1), 32'h0);
        check("rst_frame1", 32'(fr1), 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_seg4", 32'(seg4), 32'h81);
        check("first_an4", 32'(an4), 32'hE);
        repeat (30) @(negedge clk);

        load1  = 1'b1;
        value1 = 4'hE;
        dp1    = 1'b0;
        load4(16'h1A3F, 4'b0100);
        load1  = 1'b0;
        @(negedge clk);
        check("one_digit_E", 32'(seg1), 32'hB0);
        repeat (12) @(negedge clk);
        wait_an(4'hB);
        check("dig2_dp", 32'(seg4), 32'h08);
        wait_an(4'h7);
        check("dig3", 32'(seg4), 32'hCF);
        wait_an(4'hE);
        check("dig0", 32'(seg4), 32'hB8);

        blank_lz = 1'b1;
        load4(16'h0050, 4'b0000);
        repeat (14) @(negedge clk);
        wait_an(4'h7);
        check("blank_d3", 32'(seg4), 32'hFF);
        wait_an(4'hD);
        check("blank_d1", 32'(seg4), 32'hA4);
        load4(16'h0000, 4'b0000);
        repeat (14) @(negedge clk);
        wait_an(4'hD);
        check("zero_d1", 32'(seg4), 32'hFF);
        wait_an(4'hE);
        check("zero_d0", 32'(seg4), 32'h81);
        blank_lz = 1'b0;
        repeat (14) @(negedge clk);

        for (int k = 0; k < 4 && (m_t % 3) != 2; k++) @(negedge clk);
        load4(16'h7777, 4'b0000);
        @(negedge clk);
        check("align_load", 32'(seg4), 32'h8F);
        repeat (14) @(negedge clk);

        wait_an(4'hB);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_seg4", 32'(seg4), 32'h0FF);
        check("async_an4", 32'(an4), 32'hF);
        check("async_seg1", 32'(seg1), 32'h0FF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_an4", 32'(an4), 32'hE);
        check("restart_seg4", 32'(seg4), 32'h81);
        repeat (26) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
